// File: rtl/lwdf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lwdf_pkg
// Description : Shared types and constants for the LWDF adaptor scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lwdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } lwdf_state_t;

  localparam int c_timeout_default = 15;

  // Adaptor index width; a single adaptor still gets a 1-bit index.
  function automatic int lwdf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lwdf_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : lwdf_sched_if
// Description : Sample stream, result stream and shared-datapath signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface lwdf_sched_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              dp_start;
  logic [IDX_W-1:0]  dp_idx;
  logic [DATA_W-1:0] dp_sample;
  logic              dp_done;
  logic [DATA_W-1:0] dp_result;
  logic              dp_wr;

  // Environment side: sample source, result sink and datapath.
  modport master (
    output in_valid, in_data, out_ready, dp_done, dp_result,
    input  in_ready, out_valid, out_data, dp_start, dp_idx, dp_sample, dp_wr
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, out_ready, dp_done, dp_result,
    output in_ready, out_valid, out_data, dp_start, dp_idx, dp_sample, dp_wr
  );

endinterface
`default_nettype wire

// File: rtl/lwdf_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : lwdf_sat_cnt
// Description : Width-parameterised up-counter with clear, saturating at max.
// Revision    : 1.0 - initial release
// ============================================================================
module lwdf_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] c_max = '1;

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/lwdf_sched.sv
`default_nettype none
// ============================================================================
// Module      : lwdf_sched
// Description : Sequences NUM_ADAPTORS adaptor ops per sample over a shared
//               datapath with a per-op timeout. Optional LWDF_SCHED_OVERRUN_EN
//               adds an 8-bit saturating overrun_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module lwdf_sched
  import lwdf_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int NUM_ADAPTORS = 5,
  parameter int TIMEOUT      = c_timeout_default
) (
  input  logic       clk,
  input  logic       rst,
  lwdf_sched_if.slave bus,
  output logic       busy,
  output logic       err
`ifdef LWDF_SCHED_OVERRUN_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);

  localparam int                 c_idx_w    = lwdf_idx_w(NUM_ADAPTORS);
  localparam logic [c_idx_w-1:0] c_last_k   = c_idx_w'(NUM_ADAPTORS - 1);
  localparam logic [7:0]         c_tmo_last = 8'(TIMEOUT - 1);

  lwdf_state_t        r_state;
  logic [c_idx_w-1:0] r_k;
  logic               r_in_ready;
  logic               r_dp_start;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_err;
  logic [DATA_W-1:0]  r_out_data;
  logic [DATA_W-1:0]  r_dp_sample;

  logic               w_done_in_wait;
  logic               w_expire;
  logic               w_tmo_clr;
  logic               w_tmo_inc;
  logic [7:0]         w_tmo_cnt;

  assign w_done_in_wait = (r_state == ST_WAIT) && bus.dp_done;
  assign w_tmo_clr      = (r_state == ST_ISSUE);
  assign w_tmo_inc      = (r_state == ST_WAIT) && !bus.dp_done;
  // Counter holds the number of completed silent WAIT cycles, so this is the
  // last one; a dp_done arriving here still completes normally.
  assign w_expire       = (r_state == ST_WAIT) && !bus.dp_done && (w_tmo_cnt == c_tmo_last);

  lwdf_sat_cnt #(
    .WIDTH (8)
  ) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_tmo_clr),
    .inc (w_tmo_inc),
    .cnt (w_tmo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_dp_start  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_out_data  <= '0;
      r_dp_sample <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_dp_sample <= bus.in_data;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_dp_start  <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_dp_start <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.dp_done) begin
            if (r_k == c_last_k) begin
              r_out_data  <= bus.dp_result;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_k        <= r_k + c_idx_w'(1);
              r_dp_start <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end else if (w_expire) begin
            r_err      <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.dp_start  = r_dp_start;
  assign bus.dp_idx    = r_k;
  assign bus.dp_sample = r_dp_sample;
  // Commit strobe is combinational so the state register captures dp_result
  // in the same cycle it is valid.
  assign bus.dp_wr     = w_done_in_wait;
  assign busy          = r_busy;
  assign err           = r_err;

`ifdef LWDF_SCHED_OVERRUN_EN
  lwdf_sat_cnt #(
    .WIDTH (8)
  ) u_ovr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (bus.in_valid && !r_in_ready),
    .cnt (overrun_cnt)
  );
`endif

endmodule
`default_nettype wire
